fpu_mul_seq: RTL

FPU_MUL_SEQ -- requirements
Module: fpu_mul_seq

---
 rtl/fpu_mul_seq_if.sv | 37 +++
 rtl/fpu_mul_seq.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/fpu_mul_seq_if.sv
// -----------------------------------------------------------------------------
// fpu_mul_seq_if
// Bundle of control, operand and result signals between the register file
// (master) and the sequential binary32 multiplier (slave).
//   start            launch pulse, one cycle, operands valid alongside it
//   fpu_rst_w        synchronous abort/clear strobe
//   operand1/2       IEEE-754 binary32 multiplicand / multiplier
//   busy             operation in flight
//   done             one-cycle completion pulse
//   result           binary32 product, held until next done or clear
//   flag_*           invalid / overflow / underflow / inexact, held with result
// -----------------------------------------------------------------------------
interface fpu_mul_seq_if;
    logic        start;
    logic        fpu_rst_w;
    logic [31:0] operand1;
    logic [31:0] operand2;
    logic        busy;
    logic        done;
    logic [31:0] result;
    logic        flag_invalid;
    logic        flag_overflow;
    logic        flag_underflow;
    logic        flag_inexact;

    modport master (
        output start, fpu_rst_w, operand1, operand2,
        input  busy, done, result,
        input  flag_invalid, flag_overflow, flag_underflow, flag_inexact
    );

    modport slave (
        input  start, fpu_rst_w, operand1, operand2,
        output busy, done, result,
        output flag_invalid, flag_overflow, flag_underflow, flag_inexact
    );
endinterface

// File: rtl/fpu_mul_seq.sv
// -----------------------------------------------------------------------------
// fpu_mul_seq
// Sequential IEEE-754 binary32 multiplier, round-to-nearest-even.
// Subnormal inputs are flushed to signed zero; results that would be
// subnormal are flushed to signed zero with underflow+inexact.
// Ports:
//   clk       clock, rising edge
//   reset_n   asynchronous active-low reset
//   io_bus    fpu_mul_seq_if.slave (start/operands in, busy/done/result/flags out)
// Build option:
//   FPU_MUL_RADIX4_EN  when defined, the shift-add multiplier retires two
//                      multiplier bits per cycle instead of one. Results are
//                      identical in both builds; only normal-path latency
//                      changes.
// -----------------------------------------------------------------------------
module fpu_mul_seq (
    input  logic         clk,
    input  logic         reset_n,
    fpu_mul_seq_if.slave io_bus
);
    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_UNPACK = 3'd1,
        S_MULT   = 3'd2,
        S_NORM   = 3'd3,
        S_ROUND  = 3'd4,
        S_DONE   = 3'd5
    } state_t;

`ifdef FPU_MUL_RADIX4_EN
    localparam int         STEP_BITS = 2;
    localparam logic [4:0] LAST_CNT  = 5'd11;
`else
    localparam int         STEP_BITS = 1;
    localparam logic [4:0] LAST_CNT  = 5'd23;
`endif
    localparam logic [31:0] QNAN = 32'h7FC0_0000;

    state_t             r_state;
    state_t             w_next;
    logic [31:0]        r_op_a;
    logic [31:0]        r_op_b;
    logic               r_sign;
    logic signed [9:0]  r_exp;
    logic [47:0]        r_prod;
    logic [47:0]        r_mcand;
    logic [23:0]        r_mplier;
    logic [4:0]         r_cnt;
    logic [22:0]        r_mant;
    logic               r_guard;
    logic               r_rnd;
    logic               r_sticky;
    logic [31:0]        r_res_pend;
    logic [3:0]         r_flg_pend;     // {invalid, overflow, underflow, inexact}
    logic               r_busy;
    logic               r_done;
    logic [31:0]        r_result;
    logic [3:0]         r_flags;

    logic [7:0]         w_exp_a;
    logic [7:0]         w_exp_b;
    logic [22:0]        w_man_a;
    logic [22:0]        w_man_b;
    logic               w_sign;
    logic               w_zero_a, w_zero_b, w_inf_a, w_inf_b;
    logic               w_nan_a, w_nan_b, w_snan_a, w_snan_b;
    logic               w_special;
    logic [31:0]        w_spec_res;
    logic               w_spec_inv;
    logic [47:0]        w_mcand;
    logic [23:0]        w_mplier;
    logic [47:0]        w_acc;
    logic [47:0]        w_step;
    logic               w_round_up;
    logic [23:0]        w_mant_rnd;
    logic signed [9:0]  w_exp_rnd;
    logic [31:0]        w_rnd_res;
    logic [3:0]         w_rnd_flg;

    assign w_exp_a = r_op_a[30:23];
    assign w_exp_b = r_op_b[30:23];
    assign w_man_a = r_op_a[22:0];
    assign w_man_b = r_op_b[22:0];
    assign w_sign  = r_op_a[31] ^ r_op_b[31];

    // Operand classification and the result for NaN / infinity / zero inputs.
    always_comb begin
        w_zero_a   = (w_exp_a == 8'd0);     // subnormals count as zero
        w_zero_b   = (w_exp_b == 8'd0);
        w_inf_a    = (w_exp_a == 8'hFF) && (w_man_a == 23'd0);
        w_inf_b    = (w_exp_b == 8'hFF) && (w_man_b == 23'd0);
        w_nan_a    = (w_exp_a == 8'hFF) && (w_man_a != 23'd0);
        w_nan_b    = (w_exp_b == 8'hFF) && (w_man_b != 23'd0);
        w_snan_a   = w_nan_a && !w_man_a[22];
        w_snan_b   = w_nan_b && !w_man_b[22];
        w_special  = w_zero_a || w_zero_b || (w_exp_a == 8'hFF) || (w_exp_b == 8'hFF);
        w_spec_res = 32'h0000_0000;
        w_spec_inv = 1'b0;
        if (w_nan_a || w_nan_b) begin
            w_spec_res = QNAN;
            w_spec_inv = w_snan_a || w_snan_b;
        end else if ((w_inf_a && w_zero_b) || (w_zero_a && w_inf_b)) begin
            w_spec_res = QNAN;
            w_spec_inv = 1'b1;
        end else if (w_inf_a || w_inf_b) begin
            w_spec_res = {w_sign, 8'hFF, 23'h00_0000};
        end else begin
            w_spec_res = {w_sign, 31'h0000_0000};
        end
    end

    // One shift-add step. The first step runs on the UNPACK edge straight
    // from the latched operands, so MULT only needs the remaining steps.
    always_comb begin
        if (r_state == S_UNPACK) begin
            w_mcand  = {24'h00_0000, 1'b1, w_man_a};
            w_mplier = {1'b1, w_man_b};
            w_acc    = 48'h0;
        end else begin
            w_mcand  = r_mcand;
            w_mplier = r_mplier;
            w_acc    = r_prod;
        end
        w_step = w_acc + (w_mplier[0] ? w_mcand : 48'h0);
`ifdef FPU_MUL_RADIX4_EN
        w_step = w_step + (w_mplier[1] ? {w_mcand[46:0], 1'b0} : 48'h0);
`endif
    end

    // Round-to-nearest-even and exponent range handling.
    always_comb begin
        w_round_up = r_guard & (r_rnd | r_sticky | r_mant[0]);
        w_mant_rnd = {1'b0, r_mant} + {23'h00_0000, w_round_up};
        w_exp_rnd  = r_exp + (w_mant_rnd[23] ? 10'sd1 : 10'sd0);
        if (w_exp_rnd >= 10'sd255) begin
            w_rnd_res = {r_sign, 8'hFF, 23'h00_0000};
            w_rnd_flg = 4'b0101;
        end else if (w_exp_rnd <= 10'sd0) begin
            w_rnd_res = {r_sign, 31'h0000_0000};
            w_rnd_flg = 4'b0011;
        end else begin
            // on mantissa carry-out the low 23 bits are already zero
            w_rnd_res = {r_sign, w_exp_rnd[7:0], w_mant_rnd[22:0]};
            w_rnd_flg = {3'b000, r_guard | r_rnd | r_sticky};
        end
    end

    // FSM state register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // FSM next-state logic; the abort strobe overrides everything, including start.
    always_comb begin
        w_next = r_state;
        if (io_bus.fpu_rst_w) begin
            w_next = S_IDLE;
        end else begin
            case (r_state)
                S_IDLE:   w_next = io_bus.start ? S_UNPACK : S_IDLE;
                S_UNPACK: w_next = w_special ? S_DONE : S_MULT;
                S_MULT:   w_next = (r_cnt == LAST_CNT) ? S_NORM : S_MULT;
                S_NORM:   w_next = S_ROUND;
                S_ROUND:  w_next = S_DONE;
                S_DONE:   w_next = S_IDLE;
                default:  w_next = S_IDLE;
            endcase
        end
    end

    // Datapath and registered outputs.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_op_a <= 32'h0;  r_op_b <= 32'h0;  r_sign <= 1'b0;  r_exp <= 10'sd0;
            r_prod <= 48'h0;  r_mcand <= 48'h0; r_mplier <= 24'h0; r_cnt <= 5'd0;
            r_mant <= 23'h0;  r_guard <= 1'b0;  r_rnd <= 1'b0;   r_sticky <= 1'b0;
            r_res_pend <= 32'h0; r_flg_pend <= 4'h0;
            r_busy <= 1'b0;   r_done <= 1'b0;   r_result <= 32'h0; r_flags <= 4'h0;
        end else if (io_bus.fpu_rst_w) begin
            r_op_a <= 32'h0;  r_op_b <= 32'h0;  r_sign <= 1'b0;  r_exp <= 10'sd0;
            r_prod <= 48'h0;  r_mcand <= 48'h0; r_mplier <= 24'h0; r_cnt <= 5'd0;
            r_mant <= 23'h0;  r_guard <= 1'b0;  r_rnd <= 1'b0;   r_sticky <= 1'b0;
            r_res_pend <= 32'h0; r_flg_pend <= 4'h0;
            r_busy <= 1'b0;   r_done <= 1'b0;   r_result <= 32'h0; r_flags <= 4'h0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (io_bus.start) begin
                        r_op_a <= io_bus.operand1;
                        r_op_b <= io_bus.operand2;
                        r_busy <= 1'b1;
                    end
                end
                S_UNPACK: begin
                    r_sign <= w_sign;
                    if (w_special) begin
                        r_res_pend <= w_spec_res;
                        r_flg_pend <= {w_spec_inv, 3'b000};
                    end else begin
                        r_prod   <= w_step;
                        r_mcand  <= w_mcand << STEP_BITS;
                        r_mplier <= w_mplier >> STEP_BITS;
                        r_cnt    <= 5'd1;
                        r_exp    <= $signed({2'b00, w_exp_a}) + $signed({2'b00, w_exp_b}) - 10'sd127;
                    end
                end
                S_MULT: begin
                    r_prod   <= w_step;
                    r_mcand  <= w_mcand << STEP_BITS;
                    r_mplier <= w_mplier >> STEP_BITS;
                    r_cnt    <= r_cnt + 5'd1;
                end
                S_NORM: begin
                    // product of two [1,2) significands lies in [1,4)
                    if (r_prod[47]) begin
                        r_mant   <= r_prod[46:24];
                        r_guard  <= r_prod[23];
                        r_rnd    <= r_prod[22];
                        r_sticky <= |r_prod[21:0];
                        r_exp    <= r_exp + 10'sd1;
                    end else begin
                        r_mant   <= r_prod[45:23];
                        r_guard  <= r_prod[22];
                        r_rnd    <= r_prod[21];
                        r_sticky <= |r_prod[20:0];
                    end
                end
                S_ROUND: begin
                    r_res_pend <= w_rnd_res;
                    r_flg_pend <= w_rnd_flg;
                end
                S_DONE: begin
                    r_result <= r_res_pend;
                    r_flags  <= r_flg_pend;
                    r_done   <= 1'b1;
                    r_busy   <= 1'b0;
                end
                default: begin
                    r_busy <= 1'b0;
                end
            endcase
        end
    end

    assign io_bus.busy           = r_busy;
    assign io_bus.done           = r_done;
    assign io_bus.result         = r_result;
    assign io_bus.flag_invalid   = r_flags[3];
    assign io_bus.flag_overflow  = r_flags[2];
    assign io_bus.flag_underflow = r_flags[1];
    assign io_bus.flag_inexact   = r_flags[0];
endmodule
